// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle MIPS control FSM. Sequences each instruction through
//   fetch / decode / execute / memory / writeback and drives the datapath
//   mux selects, register-file and memory enables and the 3-bit ALU control.
//   Memory accesses wait on mem_ready. A wait-cycle counter flags a timeout
//   after MAX_WAIT stalled cycles. MAX_WAIT = 0 disables the timeout.
//
// Parameters
//   WAIT_W    width of the memory wait-cycle counter
//   MAX_WAIT  stalled cycles that trigger a timeout (0 = never), < 2**WAIT_W
//
// Optional feature
//   MULTICYCLE_BNE_EN  when defined, opcode 000101 (bne) is a branch taken on
//                      ~zero. When undefined, that opcode is illegal.
//
// Ports
//   clk          clock
//   rst          synchronous, active-low reset; forces every output to 0
//   ins          instruction register contents (stable between IRWrite loads)
//   mem_ready    memory completes the current access this cycle
//   zero         ALU zero flag
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   IRWrite      instruction register load
//   PCWrite      PC load (branch condition already folded in)
//   ALUSrcA      ALU A select: 0 = PC, 1 = rs
//   ALUSrcB      ALU B select: 00 rt, 01 4, 10 signext imm, 11 signext imm<<2
//   PCSrc        PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   RegDst, RegWrite, MemRead, MemWrite, MemToReg   classic control meanings
//   outOp        ALU control
//   retire       one-cycle pulse on the final cycle of a completed instruction
//   illegal      sticky: unsupported opcode or funct seen
//   mem_timeout  sticky: a memory access stalled for MAX_WAIT cycles
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic [2:0]  outOp,
  output logic        retire,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_plus;
  logic              mem_wait, timeout_hit;
  logic              set_illegal, set_timeout;
  logic              illegal_q, timeout_q;
  logic [5:0]        opcode, funct;
  logic [2:0]        alu_funct;
  logic              funct_ok, is_bne;
  logic              unused_ins_bits;

  assign opcode          = ins[31:26];
  assign funct           = ins[5:0];
  // Register fields and immediates feed the datapath, not this controller.
  assign unused_ins_bits = ^ins[25:6];

`ifdef MULTICYCLE_BNE_EN
  assign is_bne = (opcode == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  // R-type funct to ALU control. 011 marks an unsupported funct.
  always_comb begin
    alu_funct = 3'b011;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: alu_funct = 3'b010;
      6'b100010: alu_funct = 3'b110;
      6'b100100: alu_funct = 3'b000;
      6'b100101: alu_funct = 3'b001;
      6'b101010: alu_funct = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // A stall is a cycle in a memory-access state without mem_ready. The
  // timeout fires on the stall that would bring the count to MAX_WAIT, so
  // mem_ready arriving in that same cycle wins.
  assign mem_wait    = !mem_ready && (state == FETCH || state == MEMRD || state == MEMWR);
  assign wait_plus   = {1'b0, wait_cnt} + (WAIT_W+1)'(1);
  assign timeout_hit = (MAX_WAIT != 0) && mem_wait && (wait_plus == (WAIT_W+1)'(MAX_WAIT));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
      // Counts consecutive stalls only. Any progress or a timeout restarts it.
      if (mem_wait && !timeout_hit) wait_cnt <= wait_plus[WAIT_W-1:0];
      else                          wait_cnt <= '0;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    outOp       = 3'b010;
    retire      = 1'b0;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)        state_next  = DECODE;
        else if (timeout_hit) set_timeout = 1'b1;  // keep requesting
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXEC;
          OP_ADDI:      state_next = ADDIEX;
          OP_BEQ:       state_next = BRANCH;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          OP_J:         state_next = JUMP;
          default: begin
            state_next  = FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = MEMWB;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          state_next  = FETCH;
        end
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          state_next  = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        outOp   = alu_funct;
        if (funct_ok) begin
          state_next = ALUWB;
        end else begin
          state_next  = FETCH;
          set_illegal = 1'b1;
        end
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        outOp      = 3'b110;
        PCSrc      = 2'b01;
        PCWrite    = is_bne ? ~zero : zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Reset silences the datapath immediately, even before the clock edge.
    if (!rst) begin
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSrc    = 2'b00;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      outOp    = 3'b000;
      retire   = 1'b0;
    end
  end

  assign illegal     = rst & illegal_q;
  assign mem_timeout = rst & timeout_q;

endmodule
